// File: rtl/spi_slave_gen.sv
// SPI slave front-end for the single-port RAM: deserialises {cmd, payload} frames and returns read data on MISO.
// Optional macro SPI_FRAME_ERR_EN enables the frame_err abort strobe; otherwise frame_err is tied low.
module spi_slave_gen #(
  parameter int PAY_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [PAY_W+1:0]  rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int FRAME_W = PAY_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {PH_RX, PH_WAIT_TX, PH_SEND, PH_DONE} phase_t;

  state_t             r_state;
  phase_t             r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rd_pend;
  logic [FRAME_W-1:0] r_rx_shift;
  logic [DATA_W-2:0]  r_tx_shift;
  logic               r_miso;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_FRAME_ERR_EN
  logic r_frame_err;
  logic w_err_cond;
  // An abort is an error only while bits are still owed in either direction.
  assign w_err_cond = ((r_state != IDLE) && (r_phase == PH_RX) && (r_cnt < FRAME_CNT)) ||
                      ((r_state == READ_DATA) && (r_phase == PH_SEND));
  assign frame_err  = r_frame_err;
`else
  assign frame_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_phase    <= PH_RX;
      r_cnt      <= '0;
      r_rd_pend  <= 1'b0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
      if (SS_n) begin
`ifdef SPI_FRAME_ERR_EN
        r_frame_err <= w_err_cond;
`endif
        r_state <= IDLE;
        r_phase <= PH_RX;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= CHK_CMD;
            r_phase    <= PH_RX;
            r_cnt      <= '0;
            r_rx_shift <= '0;
          end
          CHK_CMD: begin
            r_rx_shift <= {r_rx_shift[FRAME_W-2:0], MOSI};
            r_cnt      <= CNT_W'(1);
            // A pending address turns a read command into the data phase.
            if (!MOSI)          r_state <= WRITE;
            else if (r_rd_pend) r_state <= READ_DATA;
            else                r_state <= READ_ADD;
          end
          default: begin
            case (r_phase)
              PH_RX: begin
                if (r_cnt < FRAME_CNT) begin
                  r_rx_shift <= {r_rx_shift[FRAME_W-2:0], MOSI};
                  r_cnt      <= r_cnt + CNT_W'(1);
                end else begin
                  r_rx_data  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
                  if (r_state == READ_DATA) begin
                    r_phase <= PH_WAIT_TX;
                    r_cnt   <= '0;
                  end else begin
                    r_phase <= PH_DONE;
                  end
                  if (r_state == READ_ADD) r_rd_pend <= 1'b1;
                end
              end
              PH_WAIT_TX: begin
                if (tx_valid) begin
                  r_tx_shift <= tx_data[DATA_W-2:0];
                  r_miso     <= tx_data[DATA_W-1];
                  r_cnt      <= CNT_W'(1);
                  r_phase    <= PH_SEND;
                end
              end
              PH_SEND: begin
                if (r_cnt < DATA_CNT) begin
                  r_miso     <= r_tx_shift[DATA_W-2];
                  r_tx_shift <= r_tx_shift << 1;
                  r_cnt      <= r_cnt + CNT_W'(1);
                end else begin
                  r_miso    <= 1'b0;
                  r_rd_pend <= 1'b0;
                  r_phase   <= PH_DONE;
                end
              end
              PH_DONE: begin
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen (PAY_W=8, DATA_W=8) with immediate-assertion checks.
module tb_spi_slave_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

`ifdef SPI_FRAME_ERR_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  spi_slave_gen #(.PAY_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
  endtask

  // Shifts the n leading bits of v, MSB first; no strobe or MISO activity expected meanwhile.
  task automatic send_bits(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = v[9-i];
      tick();
      chk("rx_bit_valid", rx_valid, 0);
      chk("rx_bit_miso", MISO, 0);
    end
  endtask

  task automatic complete_frame(input logic [9:0] exp);
    tick();
    chk("done_valid", rx_valid, 1);
    chk("done_data", rx_data, exp);
    chk("done_miso", MISO, 0);
  endtask

  task automatic end_frame(input logic exp_err);
    SS_n = 1'b1;
    tick();
    chk("end_err", frame_err, exp_err);
    chk("end_miso", MISO, 0);
    tick();
    chk("end_err_clear", frame_err, 0);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick(); tick();
    chk("rst_miso", MISO, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_rd_pend", dut.r_rd_pend, 0);
    rst_n = 1'b1;
    tick();
    $display("step reset released");

    // Write frame
    start_frame();
    send_bits(10'b00_1010_0101, 10);
    complete_frame(10'h0A5);
    chk("wr_rd_pend", dut.r_rd_pend, 0);
    tick();
    chk("wr_valid_one_cycle", rx_valid, 0);
    end_frame(1'b0);
    $display("step write rx_data=%h", rx_data);

    // Read address, then read data C3
    start_frame();
    send_bits(10'b10_0011_1100, 10);
    complete_frame(10'h23C);
    chk("ra_rd_pend", dut.r_rd_pend, 1);
    end_frame(1'b0);
    start_frame();
    send_bits(10'b11_0000_0000, 10);
    complete_frame(10'h300);
    tx_data = 8'hC3; tx_valid = 1'b1;
    pat = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      tick();
      tx_valid = 1'b0;
      chk("rd_c3_bit", MISO, pat[7-i]);
    end
    tick();
    chk("rd_c3_tail", MISO, 0);
    chk("rd_c3_pend", dut.r_rd_pend, 0);
    end_frame(1'b0);
    $display("step read C3 done");

    // Abort a write after 5 bits
    start_frame();
    send_bits(10'b00_1010_0000, 5);
    SS_n = 1'b1;
    tick();
    chk("abort_valid", rx_valid, 0);
    chk("abort_err", frame_err, FE);
    chk("abort_keep_data", rx_data, 10'h300);
    tick();
    chk("abort_err_clear", frame_err, 0);
    $display("step write abort");

    // Early and held tx_valid around a read-data frame
    start_frame();
    send_bits(10'b10_0101_0101, 10);
    complete_frame(10'h255);
    end_frame(1'b0);
    tx_data = 8'hA5; tx_valid = 1'b1;
    start_frame();
    send_bits(10'b11_1111_0000, 10);
    complete_frame(10'h3F0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rd_a5_bit", MISO, pat[7-i]);
    end
    tick();
    chk("rd_a5_tail", MISO, 0);
    chk("rd_a5_pend", dut.r_rd_pend, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_resend", MISO, 0);
    end
    end_frame(1'b0);
    $display("step early/held tx_valid");

    // cmd=11 with nothing pending decodes as read address
    start_frame();
    send_bits(10'b11_1111_1111, 10);
    complete_frame(10'h3FF);
    chk("c11_rd_pend", dut.r_rd_pend, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c11_no_miso", MISO, 0);
    end
    tx_valid = 1'b0;
    end_frame(1'b0);
    $display("step cmd11 as read address");

    // SEND aborted by SS_n keeps the pending address
    start_frame();
    send_bits(10'b11_1010_1010, 10);
    complete_frame(10'h3AA);
    tx_data = 8'hF0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("sab_bit7", MISO, 1);
    tick();
    chk("sab_bit6", MISO, 1);
    end_frame(FE);
    chk("sab_rd_pend", dut.r_rd_pend, 1);
    $display("step send abort");

    // Asynchronous reset in the middle of SEND
    start_frame();
    send_bits(10'b11_0000_0000, 10);
    complete_frame(10'h300);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ars_bit7", MISO, 1);
    tick();
    chk("ars_bit6", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ars_miso", MISO, 0);
    chk("ars_rx_valid", rx_valid, 0);
    chk("ars_rd_pend", dut.r_rd_pend, 0);
    chk("ars_rx_data", rx_data, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ars_state_idle", 32'(dut.r_state), 0);
    start_frame();
    send_bits(10'b01_0101_0101, 10);
    complete_frame(10'h155);
    end_frame(1'b0);
    $display("step async reset mid-send");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
